// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 2^ADDR_WIDTH x 32-bit words with little-endian byte-lane writes,
// programmable wait states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  state_e                state_q;
  logic [2:0]            waitCnt_q;
  logic                  dataPhase_q;
  logic                  isWrite_q;
  logic [ADDR_WIDTH-1:0] wordAddr_q;
  logic [3:0]            byteEn_q;
  logic                  hreadyOut_q;
  logic                  hresp_q;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic       accept;
  logic       reqErr;
  logic [3:0] byteEn;
  logic       completing;
  logic       memWe;
  logic       unused_ok;

  assign accept = HSEL & HTRANS[1] & HREADY;

  always_comb begin
    reqErr = 1'b0;
    if (HSIZE > 3'd2)                        reqErr = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])           reqErr = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b0) reqErr = 1'b1;
    if ((HADDR >> (ADDR_WIDTH + 2)) != 32'd0) reqErr = 1'b1;
  end

  always_comb begin
    byteEn = 4'b0000;
    case (HSIZE)
      3'd0:    byteEn = 4'b0001 << HADDR[1:0];
      3'd1:    byteEn = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // A good transfer's data phase completes in the IDLE-state cycle that follows its waits.
  assign completing = (state_q == IDLE) & dataPhase_q;
  assign memWe      = completing & isWrite_q & ~HRESET;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      waitCnt_q   <= 3'd0;
      dataPhase_q <= 1'b0;
      isWrite_q   <= 1'b0;
      wordAddr_q  <= '0;
      byteEn_q    <= 4'b0000;
      hreadyOut_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ERR2: begin
          state_q     <= IDLE;
          dataPhase_q <= 1'b0;
          hreadyOut_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            if (reqErr) begin
              state_q     <= ERR1;
              hreadyOut_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              dataPhase_q <= 1'b1;
              isWrite_q   <= HWRITE;
              wordAddr_q  <= HADDR[ADDR_WIDTH+1:2];
              byteEn_q    <= byteEn;
              if (WAIT_STATES != 0) begin
                state_q     <= WAIT;
                waitCnt_q   <= 3'(WAIT_STATES);
                hreadyOut_q <= 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (waitCnt_q == 3'd1) begin
            state_q     <= IDLE;
            waitCnt_q   <= 3'd0;
            hreadyOut_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q - 3'd1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyOut_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          hreadyOut_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Memory contents survive reset; only the addressed byte lanes are written.
  always_ff @(posedge HCLK) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn_q[i]) mem[wordAddr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyOut_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = (completing & ~isWrite_q) ? mem[wordAddr_q] : 32'd0;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Testbench for ahb_sram_slave: two instances (2 wait states and 0 wait states) driven by a
// pipelined AHB master, checked against a byte-array model of the memory.
module tb_ahb_sram_slave;

  localparam int AW  = 6;
  localparam int WS0 = 2;
  localparam int WS1 = 0;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        hreset    [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [3:0]  hprot     [2];
  logic        hmastlock [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  // Single-slave bus: the global ready is this slave's own ready.
  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0)) dut0 (
    .HCLK(HCLK), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
    .HMASTLOCK(hmastlock[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) dut1 (
    .HCLK(HCLK), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
    .HMASTLOCK(hmastlock[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  logic        xWrite [64];
  logic [1:0]  xTrans [64];
  logic [31:0] xAddr  [64];
  logic [2:0]  xSize  [64];
  logic [31:0] xData  [64];
  logic        rResp  [64];
  logic [31:0] rData  [64];
  int          rCyc   [64];
  logic        rErr1  [64];

  logic [7:0] mdl [2][256];
  int nChecks = 0;
  int nFail   = 0;

  // Reference: memory is a flat byte array; a transfer is legal if naturally aligned and in range.
  function automatic void modelXfer(input int k, input logic w, input logic [31:0] a,
                                    input logic [2:0] sz, input logic [31:0] wd,
                                    output logic expResp, output logic [31:0] expData,
                                    output int expCyc);
    int  nb;
    bit  bad;
    nb      = 1 << sz;
    bad     = (sz > 3'd2) || ((a % nb) != 0) || (a >= 32'd256);
    expResp = bad;
    expData = 32'd0;
    expCyc  = bad ? 2 : (((k == 0) ? WS0 : WS1) + 1);
    if (!bad) begin
      if (w) for (int b = 0; b < nb; b++) mdl[k][a + b] = wd[8*((a + b) % 4) +: 8];
      else   for (int b = 0; b < 4; b++)  expData[8*b +: 8] = mdl[k][(a & ~32'd3) + b];
    end
  endfunction

  task automatic setX(input int i, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d);
    xWrite[i] = w; xAddr[i] = a; xSize[i] = sz; xData[i] = d; xTrans[i] = T_NONSEQ;
  endtask

  task automatic driveAddr(input int k, input int i, input int n);
    if (i < n) begin
      hsel[k] = 1'b1; htrans[k] = xTrans[i]; haddr[k] = xAddr[i];
      hwrite[k] = xWrite[i]; hsize[k] = xSize[i];
    end else begin
      hsel[k] = 1'b0; htrans[k] = T_IDLE;
    end
    hburst[k] = 3'($urandom); hprot[k] = 4'($urandom); hmastlock[k] = 1'($urandom);
  endtask

  // Pipelined master: address of the next transfer overlaps the data phase of the current one.
  task automatic applyStimulus(input int k, input int n);
    int   issue, dp, guard;
    logic rdy;
    issue = 0; dp = -1; guard = 0;
    for (int i = 0; i < n; i++) begin
      rResp[i] = 1'bx; rData[i] = 'x; rCyc[i] = 0; rErr1[i] = 1'b0;
    end
    @(posedge HCLK); #1;
    driveAddr(k, issue, n);
    while ((issue < n || dp >= 0) && guard < 1000) begin
      @(negedge HCLK);
      guard++;
      rdy = hreadyout[k];
      if (dp >= 0) begin
        rCyc[dp]++;
        if (!rdy && hresp[k]) rErr1[dp] = 1'b1;
        if (rdy) begin rResp[dp] = hresp[k]; rData[dp] = hrdata[k]; end
      end
      if (rdy) begin
        if (issue < n) begin dp = issue; issue++; end
        else dp = -1;
      end
      @(posedge HCLK); #1;
      driveAddr(k, issue, n);
      hwdata[k] = (dp >= 0) ? xData[dp] : 32'd0;
    end
    nChecks++;
    if (guard >= 1000) begin
      nFail++;
      $display("[TB] FAIL bus_timeout: dut%0d got %0d cycles, required under 1000", k, guard);
    end
  endtask

  task automatic test_reset();
    logic eResp; logic [31:0] eData; int eCyc;
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0; htrans[k] = T_IDLE; haddr[k] = 32'd0; hwrite[k] = 1'b0; hsize[k] = 3'd0;
      hburst[k] = 3'd0; hprot[k] = 4'd0; hmastlock[k] = 1'b0; hwdata[k] = 32'd0; hreset[k] = 1'b0;
    end
    #1; hreset[0] = 1'b1; hreset[1] = 1'b1;
    #11;
    for (int k = 0; k < 2; k++) begin
      nChecks += 3;
      if (hreadyout[k] !== 1'b1) begin nFail++; $display("[TB] FAIL reset_ready dut%0d: got %b required 1", k, hreadyout[k]); end
      if (hresp[k] !== 1'b0) begin nFail++; $display("[TB] FAIL reset_resp dut%0d: got %b required 0", k, hresp[k]); end
      if (hrdata[k] !== 32'd0) begin nFail++; $display("[TB] FAIL reset_rdata dut%0d: got %h required 0", k, hrdata[k]); end
    end
    @(posedge HCLK); #1;
    hreset[0] = 1'b0; hreset[1] = 1'b0;
    eResp = 1'b0; eData = 32'd0; eCyc = 0;
  endtask

  task automatic test_fill(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    for (int i = 0; i < 64; i++) begin
      setX(i, 1'b1, 32'(4 * i), 3'd2, $urandom);
      if (i > 0) xTrans[i] = T_SEQ;
    end
    applyStimulus(k, 64);
    for (int i = 0; i < 64; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 3;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL fill_resp dut%0d #%0d: got %b required %b", k, i, rResp[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL fill_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL fill_rdata dut%0d #%0d: got %h required %h", k, i, rData[i], eData); end
    end
  endtask

  task automatic test_basic(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    setX(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    setX(1, 1'b0, 32'h10, 3'd2, 32'd0);
    applyStimulus(k, 2);
    for (int i = 0; i < 2; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 3;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL basic_resp dut%0d #%0d: got %b required %b", k, i, rResp[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL basic_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL basic_rdata dut%0d #%0d: got %h required %h", k, i, rData[i], eData); end
    end
    nChecks++;
    if (rData[1] !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL basic_word dut%0d: got %h required deadbeef", k, rData[1]); end
  endtask

  task automatic test_byte_lanes(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    setX(0, 1'b1, 32'h20, 3'd2, 32'h11223344);
    setX(1, 1'b1, 32'h22, 3'd0, 32'h00AA0000);
    setX(2, 1'b0, 32'h20, 3'd2, 32'd0);
    setX(3, 1'b1, 32'h26, 3'd1, 32'h5566FFFF);
    setX(4, 1'b1, 32'h25, 3'd0, 32'h0000EE00);
    setX(5, 1'b0, 32'h24, 3'd2, 32'd0);
    applyStimulus(k, 6);
    for (int i = 0; i < 6; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 3;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL lanes_resp dut%0d #%0d: got %b required %b", k, i, rResp[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL lanes_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL lanes_rdata dut%0d #%0d: got %h required %h", k, i, rData[i], eData); end
    end
    nChecks++;
    if (rData[2] !== 32'h11AA3344) begin nFail++; $display("[TB] FAIL lanes_word dut%0d: got %h required 11aa3344", k, rData[2]); end
  endtask

  task automatic test_error(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    setX(0, 1'b0, 32'h21, 3'd1, 32'd0);
    setX(1, 1'b0, 32'h20, 3'd2, 32'd0);
    setX(2, 1'b1, 32'h22, 3'd2, 32'hFFFFFFFF);
    setX(3, 1'b1, 32'h400, 3'd2, 32'h12345678);
    setX(4, 1'b1, 32'h20, 3'd3, 32'h87654321);
    setX(5, 1'b1, 32'h21, 3'd1, 32'h0BAD0BAD);
    setX(6, 1'b0, 32'h20, 3'd2, 32'd0);
    applyStimulus(k, 7);
    for (int i = 0; i < 7; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 4;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL err_resp dut%0d #%0d: got %b required %b", k, i, rResp[i], eResp); end
      if (rErr1[i] !== eResp) begin nFail++; $display("[TB] FAIL err_first_cycle dut%0d #%0d: got %b required %b", k, i, rErr1[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL err_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL err_rdata dut%0d #%0d: got %h required %h", k, i, rData[i], eData); end
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    setX(0, 1'b1, 32'h0, 3'd2, 32'hA0A0A0A0);
    setX(1, 1'b1, 32'h4, 3'd2, 32'hB1B1B1B1);
    setX(2, 1'b1, 32'h8, 3'd2, 32'hC2C2C2C2);
    setX(3, 1'b0, 32'h0, 3'd2, 32'd0);
    setX(4, 1'b0, 32'h4, 3'd2, 32'd0);
    setX(5, 1'b0, 32'h8, 3'd2, 32'd0);
    applyStimulus(k, 6);
    for (int i = 0; i < 6; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 3;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL b2b_resp dut%0d #%0d: got %b required %b", k, i, rResp[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL b2b_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL b2b_rdata dut%0d #%0d: got %h required %h", k, i, rData[i], eData); end
    end
  endtask

  task automatic test_unselected(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    @(posedge HCLK); #1;
    hsel[k] = 1'b0; htrans[k] = T_NONSEQ; hwrite[k] = 1'b1; haddr[k] = 32'h40;
    hsize[k] = 3'd2; hwdata[k] = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin @(posedge HCLK); #1; hsel[k] = 1'b1; htrans[k] = T_BUSY; end
      @(negedge HCLK);
      nChecks += 3;
      if (hreadyout[k] !== 1'b1) begin nFail++; $display("[TB] FAIL nosel_ready dut%0d c%0d: got %b required 1", k, c, hreadyout[k]); end
      if (hresp[k] !== 1'b0) begin nFail++; $display("[TB] FAIL nosel_resp dut%0d c%0d: got %b required 0", k, c, hresp[k]); end
      if (hrdata[k] !== 32'd0) begin nFail++; $display("[TB] FAIL nosel_rdata dut%0d c%0d: got %h required 0", k, c, hrdata[k]); end
    end
    setX(0, 1'b0, 32'h40, 3'd2, 32'd0);
    applyStimulus(k, 1);
    modelXfer(k, xWrite[0], xAddr[0], xSize[0], xData[0], eResp, eData, eCyc);
    nChecks += 2;
    if (rResp[0] !== eResp) begin nFail++; $display("[TB] FAIL nosel_readback_resp dut%0d: got %b required %b", k, rResp[0], eResp); end
    if (rData[0] !== eData) begin nFail++; $display("[TB] FAIL nosel_readback dut%0d: got %h required %h", k, rData[0], eData); end
  endtask

  task automatic test_random(input int k, input int n);
    logic eResp; logic [31:0] eData; int eCyc;
    logic w; logic [2:0] sz; logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      w  = 1'($urandom);
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 11))
        0: sz = 3'($urandom_range(3, 7));
        1: a = 32'($urandom_range(256, 1023));
        2: begin sz = 3'd2; a = a | 32'd2; end
        3, 4: if (i > 0 && xWrite[i-1]) begin w = 1'b0; sz = 3'd2; a = xAddr[i-1] & ~32'd3; end
        default: ;
      endcase
      setX(i, w, a, sz, $urandom);
      xTrans[i] = ($urandom_range(0, 1) != 0) ? T_SEQ : T_NONSEQ;
    end
    applyStimulus(k, n);
    for (int i = 0; i < n; i++) begin
      modelXfer(k, xWrite[i], xAddr[i], xSize[i], xData[i], eResp, eData, eCyc);
      nChecks += 4;
      if (rResp[i] !== eResp) begin nFail++; $display("[TB] FAIL rnd_resp dut%0d #%0d a=%h sz=%0d: got %b required %b", k, i, xAddr[i], xSize[i], rResp[i], eResp); end
      if (rErr1[i] !== eResp) begin nFail++; $display("[TB] FAIL rnd_first_cycle dut%0d #%0d: got %b required %b", k, i, rErr1[i], eResp); end
      if (rCyc[i] != eCyc) begin nFail++; $display("[TB] FAIL rnd_cycles dut%0d #%0d: got %0d required %0d", k, i, rCyc[i], eCyc); end
      if (rData[i] !== eData) begin nFail++; $display("[TB] FAIL rnd_rdata dut%0d #%0d a=%h: got %h required %h", k, i, xAddr[i], rData[i], eData); end
    end
  endtask

  task automatic test_reset_mid_write(input int k);
    logic eResp; logic [31:0] eData; int eCyc;
    @(posedge HCLK); #1;
    hsel[k] = 1'b1; htrans[k] = T_NONSEQ; hwrite[k] = 1'b1; haddr[k] = 32'h30; hsize[k] = 3'd2;
    @(posedge HCLK); #1;
    hsel[k] = 1'b0; htrans[k] = T_IDLE; hwdata[k] = 32'h5A5A5A5A;
    #2;
    nChecks++;
    if (hreadyout[k] !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_wait dut%0d: got %b required 0", k, hreadyout[k]); end
    hreset[k] = 1'b1;
    #1;
    nChecks += 3;
    if (hreadyout[k] !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_ready dut%0d: got %b required 1", k, hreadyout[k]); end
    if (hresp[k] !== 1'b0) begin nFail++; $display("[TB] FAIL rstmid_resp dut%0d: got %b required 0", k, hresp[k]); end
    if (hrdata[k] !== 32'd0) begin nFail++; $display("[TB] FAIL rstmid_rdata dut%0d: got %h required 0", k, hrdata[k]); end
    @(posedge HCLK); #1;
    hreset[k] = 1'b0;
    setX(0, 1'b0, 32'h30, 3'd2, 32'd0);
    applyStimulus(k, 1);
    modelXfer(k, xWrite[0], xAddr[0], xSize[0], xData[0], eResp, eData, eCyc);
    nChecks += 3;
    if (rResp[0] !== eResp) begin nFail++; $display("[TB] FAIL rstmid_read_resp dut%0d: got %b required %b", k, rResp[0], eResp); end
    if (rCyc[0] != eCyc) begin nFail++; $display("[TB] FAIL rstmid_read_cycles dut%0d: got %0d required %0d", k, rCyc[0], eCyc); end
    if (rData[0] !== eData) begin nFail++; $display("[TB] FAIL rstmid_keep_old dut%0d: got %h required %h", k, rData[0], eData); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill(0);
    test_fill(1);
    test_basic(0);
    test_basic(1);
    test_byte_lanes(0);
    test_error(0);
    test_error(1);
    test_back_to_back(1);
    test_unselected(1);
    test_random(0, 40);
    test_random(1, 40);
    test_reset_mid_write(0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
